seg_to_bin: RTL and testbench
=============================

# seg_to_bin

Scan-side decoder for the multiplexed 4-digit 7-segment bus: observes the active-low `seg`/`wela` pair driven by the display driver and recovers the four hex nibbles being shown. It synchronises the bus, waits for each digit phase to be stable, decodes the segment pattern back to a nibble, and publishes a complete, coherent 4-digit frame with a one-cycle strobe. It serves as a readback/self-check path for the frequency meter display and as a bench monitor.

## Interface
- `SETTLE`, default 1: consecutive identical synchronised samples of `{wela,seg}` required before a digit is captured; legal range 1..255.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `seg`  in  7  segment bus, active-low, bit0=a … bit6=g.
- `wela`  in  4  digit enables, active-low one-hot; 0111=digit4, 1011=digit3, 1101=digit2, 1110=digit1.
- `out1`..`out4`  out  4 each  last complete decoded frame; `out1` pairs with `wela`=1110.
- `frame_valid`  out  1  one-cycle pulse when `out1..out4` update.
- `code_err`  out  1  one-cycle pulse when a settled digit phase carries an undecodable pattern.

## Operation
- Input stage: `{wela,seg}` passes through a 2-flop synchroniser; all logic below uses the synchronised copy.
- Stability counter: increments while the synchronised sample equals the previous one, reloads to 1 on any change; saturates at `SETTLE`.
- States: IDLE (wela not legal one-hot), SETTLING (legal one-hot, count < `SETTLE`), HELD (digit captured this phase; no further capture until the sample changes).
- Legal `wela`: exactly one bit low. 1111 (blank), 0000, and multi-low patterns are ignored: no capture, no error, frame progress kept.
- Capture: on entering HELD, decode `seg`. Valid patterns (hex of seg[6:0]): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. Valid pattern writes the shadow nibble for that digit and sets its bit in a 4-bit capture mask. Any other pattern (including 7F blank) pulses `code_err`, clears the whole mask, and writes nothing.
- Recapture of a digit already in the mask overwrites its shadow nibble; no error.
- Frame completion: when the mask becomes 1111, shadows copy to `out1..out4`, `frame_valid` pulses, mask clears in the same cycle.
- Reset (any time, including mid-frame): synchroniser, counter, mask, shadows, outputs all cleared; state IDLE.

## Timing
- Reset values: `out1..out4`=0, `frame_valid`=0, `code_err`=0, mask=0000.
- Capture latency: a digit phase presented at the pins at cycle n is captured at the clock edge n+1+`SETTLE` (2 sync flops, first sample counts as 1).
- `frame_valid`/`code_err` are registered and rise the cycle after the capture edge; they are never asserted together.
- Outputs update only on a `frame_valid` cycle; otherwise hold.
- With `SETTLE`=1, one-cycle digit phases (driver free-running at full clock) are captured every cycle; a full frame every 4 cycles.
- A digit phase shorter than `SETTLE` cycles is never captured.

## Structure
- Package `seg_pkg`: the 16 segment constants, `SEG_BLANK`=7'h7F, the four `wela` one-hot constants, digit-index typedef (2-bit).
- Sub-module `seg_decode`: combinational 7-bit pattern → {valid, 4-bit nibble}; shared with future display blocks.
- Top holds synchroniser, stability counter, state, mask, shadows, outputs.

## Test plan
- Reset then drive wela 0111/1011/1101/1110 with seg 0x12/0x30/0x79/0x40 cyclically, 1 cycle each, `SETTLE`=1 -> `frame_valid` every 4 cycles, out4=5, out3=3, out2=1, out1=0.
- `SETTLE`=3, phases of 2 cycles -> no capture, no `frame_valid`, no `code_err`; lengthen phases to 4 cycles -> frames resume with correct values.
- Inject seg=0x7F on digit2 phase -> single `code_err` pulse, mask cleared, outputs keep previous frame; next clean 4 phases -> `frame_valid` with new values.
- Insert wela=1111 and 0011 between phases -> ignored, frame still completes with correct nibbles.
- Digit1 shown twice (0x19 then 0x0E) before remaining digits -> out1=F on completion, no error.
- Assert `rst_n` low after 3 digits captured -> all outputs 0 immediately; first `frame_valid` only after 4 fresh captures.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan-bus decoder.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] WELA_D1 = 4'b1110;
  localparam logic [3:0] WELA_D2 = 4'b1101;
  localparam logic [3:0] WELA_D3 = 4'b1011;
  localparam logic [3:0] WELA_D4 = 4'b0111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_HELD
  } phase_state_t;

  // Exactly one enable low means three bits high.
  function automatic logic wela_legal(input logic [3:0] w);
    return $countones(w) == 3;
  endfunction

  function automatic digit_idx_t wela_index(input logic [3:0] w);
    case (w)
      WELA_D2: return 2'd1;
      WELA_D3: return 2'd2;
      WELA_D4: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 7-segment pattern to hex nibble decoder.
// Anything outside the 16 glyphs (blank included) reports valid = 0.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_to_bin.sv
// Recovers the four hex digits shown on a multiplexed active-low 7-segment bus
// and publishes them as a coherent frame with a one-cycle strobe.
//
// state       | meaning
// ST_IDLE     | synchronised wela is not a legal one-hot enable
// ST_SETTLING | legal digit phase, stability count still below SETTLE
// ST_HELD     | digit captured this phase; wait for the sample to change
module seg_to_bin
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [3:0] wela,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] out4,
  output logic       frame_valid,
  output logic       code_err
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  logic [10:0]      sync_a;
  logic [10:0]      sync_b;
  logic [7:0]       cnt;
  logic [7:0]       cnt_next;
  phase_state_t     state;
  logic [3:0]       mask;
  logic [3:0]       mask_next;
  logic [3:0][3:0]  shadow;
  logic [3:0][3:0]  shadow_next;
  logic [3:0][3:0]  frame;
  logic             dec_valid;
  logic [3:0]       dec_nibble;
  logic             changed;
  logic             capture;
  digit_idx_t       idx;

  seg_decode u_decode (
    .pattern (sync_b[6:0]),
    .valid   (dec_valid),
    .nibble  (dec_nibble)
  );

  // sync_a holds the sample sync_b is about to take, so a mismatch means the
  // next cycle starts a new phase with a count of 1.
  always_comb begin
    changed     = (sync_a != sync_b);
    capture     = (state == ST_SETTLING) && (cnt >= SETTLE_C);
    idx         = wela_index(sync_b[10:7]);
    shadow_next = shadow;
    shadow_next[idx] = dec_nibble;
    mask_next   = mask | (4'b0001 << idx);
    if (changed)
      cnt_next = 8'd1;
    else if (cnt < SETTLE_C)
      cnt_next = cnt + 8'd1;
    else
      cnt_next = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a      <= '0;
      sync_b      <= '0;
      cnt         <= '0;
      state       <= ST_IDLE;
      mask        <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      sync_a      <= {wela, seg};
      sync_b      <= sync_a;
      cnt         <= cnt_next;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;

      if (capture) begin
        if (dec_valid) begin
          shadow <= shadow_next;
          if (mask_next == 4'hF) begin
            frame       <= shadow_next;
            frame_valid <= 1'b1;
            mask        <= '0;
          end else begin
            mask <= mask_next;
          end
        end else begin
          code_err <= 1'b1;
          mask     <= '0;
        end
      end

      if (changed)
        state <= wela_legal(sync_a[10:7]) ? ST_SETTLING : ST_IDLE;
      else if (capture)
        state <= ST_HELD;
    end
  end

  assign out1 = frame[0];
  assign out2 = frame[1];
  assign out3 = frame[2];
  assign out4 = frame[3];

endmodule

// File: tb/tb_seg_to_bin.sv
// Scoreboard bench: two decoders (SETTLE=1 and SETTLE=3) watch the same bus;
// a pin-level phase model predicts frames/errors and their arrival cycle.
module tb_seg_to_bin;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] wela = 4'hF;

  logic [3:0] o1 [2];
  logic [3:0] o2 [2];
  logic [3:0] o3 [2];
  logic [3:0] o4 [2];
  logic       fv [2];
  logic       ce [2];

  seg_to_bin #(.SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .seg(seg), .wela(wela),
    .out1(o1[0]), .out2(o2[0]), .out3(o3[0]), .out4(o4[0]),
    .frame_valid(fv[0]), .code_err(ce[0])
  );

  seg_to_bin #(.SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .seg(seg), .wela(wela),
    .out1(o1[1]), .out2(o2[1]), .out3(o3[1]), .out4(o4[1]),
    .frame_valid(fv[1]), .code_err(ce[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] frame;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [6:0]  pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          settle [2] = '{1, 3};
  logic [10:0] prev_pins;
  bit          have_prev = 1'b0;
  int          run_len = 0;
  bit          captured [2];
  logic [3:0]  mask_m [2];
  logic [3:0]  shad [2][4];
  logic [15:0] last_frame [2];

  function automatic int decode_m(logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (pat_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic int low_pos(logic [3:0] w);
    int zeros = 0;
    int pos = -1;
    for (int i = 0; i < 4; i++)
      if (!w[i]) begin
        zeros++;
        pos = i;
      end
    return (zeros == 1) ? pos : -1;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(int k, output exp_t e);
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  function automatic int qfront_due(int k);
    return (k == 0) ? q0[0].due : q1[0].due;
  endfunction

  task automatic model_reset();
    have_prev = 1'b0;
    run_len = 0;
    for (int k = 0; k < 2; k++) begin
      captured[k] = 1'b0;
      mask_m[k] = 4'h0;
      for (int d = 0; d < 4; d++) shad[k][d] = 4'h0;
    end
  endtask

  // One pin interval: a run of identical legal pins lasting SETTLE intervals
  // yields one capture, visible at the outputs three edges later.
  task automatic model_step(logic [3:0] w, logic [6:0] s);
    exp_t e;
    int d, p;
    if (!have_prev || {w, s} != prev_pins) begin
      run_len = 1;
      captured[0] = 1'b0;
      captured[1] = 1'b0;
    end else begin
      run_len++;
    end
    prev_pins = {w, s};
    have_prev = 1'b1;
    p = low_pos(w);
    for (int k = 0; k < 2; k++) begin
      if (p >= 0 && !captured[k] && run_len >= settle[k]) begin
        captured[k] = 1'b1;
        d = decode_m(s);
        e.due = cyc + 3;
        e.frame = 16'h0;
        if (d < 0) begin
          e.is_err = 1'b1;
          mask_m[k] = 4'h0;
          qpush(k, e);
        end else begin
          shad[k][p] = d[3:0];
          mask_m[k][p] = 1'b1;
          if (mask_m[k] == 4'hF) begin
            e.is_err = 1'b0;
            e.frame = {shad[k][3], shad[k][2], shad[k][1], shad[k][0]};
            mask_m[k] = 4'h0;
            qpush(k, e);
          end
        end
      end
    end
  endtask

  task automatic drive(logic [3:0] w, logic [6:0] s, int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      wela = w;
      seg = s;
      model_step(w, s);
    end
  endtask

  task automatic round(logic [6:0] s4, logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, int n);
    drive(4'b0111, s4, n);
    drive(4'b1011, s3, n);
    drive(4'b1101, s2, n);
    drive(4'b1110, s1, n);
  endtask

  task automatic do_reset();
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain_before_reset: pending=%0d required=0", q0.size() + q1.size());
    end
    @(posedge clk);
    #2;
    wela = 4'hF;
    seg = 7'h7F;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({o4[k], o3[k], o2[k], o1[k]} != 16'h0 || fv[k] || ce[k]) begin
        miscompares++;
        $display("FAIL reset_immediate[%0d]: outs=%h fv=%b ce=%b required 0", k,
                 {o4[k], o3[k], o2[k], o1[k]}, fv[k], ce[k]);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] cur;
    for (int k = 0; k < 2; k++) begin
      cur = {o4[k], o3[k], o2[k], o1[k]};
      if (!rst_n) begin
        vectors++;
        last_frame[k] = 16'h0;
        if (cur != 16'h0 || fv[k] || ce[k]) begin
          miscompares++;
          $display("FAIL reset_state[%0d]: outs=%h fv=%b ce=%b required 0", k, cur, fv[k], ce[k]);
        end
      end else if (fv[k] || ce[k]) begin
        vectors++;
        if (fv[k] && ce[k]) begin
          miscompares++;
          $display("FAIL both_pulses[%0d]: fv=1 ce=1 at cycle %0d", k, cyc);
        end else if (qsize(k) == 0) begin
          miscompares++;
          $display("FAIL unexpected_event[%0d]: fv=%b ce=%b outs=%h none expected at cycle %0d",
                   k, fv[k], ce[k], cur, cyc);
        end else begin
          qpop(k, e);
          if (e.is_err != ce[k] || e.due != cyc || (!e.is_err && e.frame != cur)) begin
            miscompares++;
            $display("FAIL event[%0d]: got err=%b outs=%h cycle=%0d required err=%b outs=%h cycle=%0d",
                     k, ce[k], cur, cyc, e.is_err, e.is_err ? last_frame[k] : e.frame, e.due);
          end
          if (!e.is_err) last_frame[k] = e.frame;
        end
      end else begin
        vectors++;
        if (cur != last_frame[k]) begin
          miscompares++;
          $display("FAIL hold[%0d]: outs=%h required %h at cycle %0d", k, cur, last_frame[k], cyc);
        end
        if (qsize(k) > 0 && qfront_due(k) <= cyc) begin
          miscompares++;
          $display("FAIL missing_event[%0d]: nothing at cycle %0d required event due %0d",
                   k, cyc, qfront_due(k));
          qpop(k, e);
          if (!e.is_err) last_frame[k] = e.frame;
        end
      end
    end
  end

  initial begin
    logic [3:0] w;
    logic [6:0] s;
    int r;
    model_reset();
    last_frame[0] = 16'h0;
    last_frame[1] = 16'h0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(4'hF, 7'h7F, 3);

    // free-running one-cycle phases: 5,3,1,0
    repeat (8) round(7'h12, 7'h30, 7'h79, 7'h40, 1);
    // two-cycle phases, then four-cycle phases
    repeat (3) round(7'h24, 7'h19, 7'h02, 7'h78, 2);
    repeat (3) round(7'h00, 7'h10, 7'h08, 7'h03, 4);

    // blank glyph on digit2
    drive(4'b0111, 7'h46, 4);
    drive(4'b1011, 7'h21, 4);
    drive(4'b1101, 7'h7F, 4);
    drive(4'b1110, 7'h06, 4);
    round(7'h79, 7'h24, 7'h30, 7'h19, 4);

    // ignored wela patterns between phases
    drive(4'b0111, 7'h0E, 4);
    drive(4'hF, 7'h40, 2);
    drive(4'b1011, 7'h12, 4);
    drive(4'b0011, 7'h40, 3);
    drive(4'b1101, 7'h02, 4);
    drive(4'b0000, 7'h79, 2);
    drive(4'b1110, 7'h78, 4);

    // digit1 recaptured before the rest
    drive(4'b1110, 7'h19, 4);
    drive(4'b1110, 7'h0E, 4);
    drive(4'b1101, 7'h10, 4);
    drive(4'b1011, 7'h08, 4);
    drive(4'b0111, 7'h03, 4);

    // reset after three captures
    drive(4'b0111, 7'h40, 4);
    drive(4'b1011, 7'h79, 4);
    drive(4'b1101, 7'h24, 4);
    drive(4'hF, 7'h7F, 8);
    do_reset();
    drive(4'b1110, 7'h30, 4);
    drive(4'hF, 7'h7F, 3);
    round(7'h19, 7'h12, 7'h02, 7'h78, 4);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) w = ~(4'b0001 << (r % 4));
      else if (r == 8) w = 4'hF;
      else w = 4'($urandom);
      if ($urandom_range(0, 9) < 9) s = pat_tab[$urandom_range(0, 15)];
      else s = 7'($urandom);
      drive(w, s, $urandom_range(1, 5));
    end

    drive(4'hF, 7'h7F, 10);
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain_end: pending=%0d required=0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
